// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: multiplexed BCD 7-segment scanner with blanking gaps, frame-synchronous updates and leading-zero blanking
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    lz_blank,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);
  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_TAB [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  typedef enum logic {S_BLANK, S_ON} state_t;
  state_t                  r_state, w_nstate;
  logic [CW-1:0]           r_cnt, w_ncnt;
  logic [IW-1:0]           r_idx, w_nidx;
  logic [4*NUM_DIGITS-1:0] r_active, r_pend, w_nact;
  logic                    r_flag, w_nflag, r_ready, r_fs;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_den;
  logic                    w_on_last, w_bl_last, w_boundary, w_accept, w_apply, w_hide;
  logic [3:0]              w_nib;
  // Output registers are loaded from next-state values so they line up with the state they describe.
  always_comb begin
    w_on_last  = (r_state == S_ON) && (r_cnt == CW'(ON_CYCLES - 1));
    w_bl_last  = (r_state == S_BLANK) && (r_cnt == CW'(BLANK_CYCLES - 1));
    w_boundary = en && w_on_last && (r_idx == IW'(NUM_DIGITS - 1));
    w_accept   = load_valid && r_ready;
    // While the scan is stopped nothing is on screen, so a pending value can go live at once.
    w_apply    = r_flag && (w_boundary || !en);
    w_nflag    = w_accept ? 1'b1 : w_apply ? 1'b0 : r_flag;
    w_nact     = w_apply ? r_pend : r_active;
    w_nstate   = !en ? S_BLANK : w_on_last ? S_BLANK : w_bl_last ? S_ON : r_state;
    w_ncnt     = (!en || w_on_last || w_bl_last) ? '0 : r_cnt + CW'(1);
    w_nidx     = !en ? '0 : w_on_last ? ((r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1)) : r_idx;
    w_nib      = w_nact[{w_nidx, 2'b00} +: 4];
    // A digit is a leading zero when it and every more significant nibble are zero.
    w_hide     = lz_blank && (w_nidx != '0) && ((w_nact >> {w_nidx, 2'b00}) == '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BLANK;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_active <= '0;
      r_pend   <= '0;
      r_flag   <= 1'b0;
      r_ready  <= 1'b1;
      r_fs     <= 1'b0;
      r_seg    <= '0;
      r_den    <= '0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_idx    <= w_nidx;
      r_active <= w_nact;
      r_pend   <= w_accept ? load_data : r_pend;
      r_flag   <= w_nflag;
      r_ready  <= !w_nflag;
      r_fs     <= w_boundary;
      r_den    <= (w_nstate == S_ON) ? NUM_DIGITS'(1) << w_nidx : '0;
      r_seg    <= (w_nstate == S_ON && !w_hide) ? SEG_TAB[w_nib] : '0;
    end
  end
  assign load_ready  = r_ready;
  assign seg         = r_seg;
  assign digit_en    = r_den;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed and random checks of the scanner against a frame-position reference model
module tb_seg7_scan_controller;
  localparam int N = 4, ON = 4, BL = 2, P = ON + BL, F = N * P;
  logic        clk = 0, rst = 1, en = 1, lz_blank = 0, load_valid = 0;
  logic [15:0] load_data = '0;
  logic        load_ready, frame_start;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  int total = 0, bad = 0;
  int          m_t = 0;
  logic [15:0] m_active = '0, m_pend = '0;
  logic        m_flag = 0, m_fs = 0;
  logic [6:0]  tab [16];
  seg7_scan_controller #(.NUM_DIGITS(N), .ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .lz_blank(lz_blank), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .seg(seg), .digit_en(digit_en),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    int pos, d;
    logic lit, hide;
    logic [15:0] hi;
    pos  = m_t % F;
    d    = pos / P;
    lit  = (pos % P) >= BL;
    hi   = m_active >> (4 * d);
    hide = lz_blank && d > 0 && hi == 0;
    chk("digit_en", 32'(digit_en), lit ? 32'(1 << d) : 0);
    chk("seg", 32'(seg), (lit && !hide) ? 32'(tab[hi[3:0]]) : 0);
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("load_ready", 32'(load_ready), 32'(!m_flag));
  endtask
  task automatic step();
    logic acc, bnd, app;
    int nt;
    acc = load_valid && !m_flag;
    nt  = en ? m_t + 1 : 0;
    bnd = en && (nt % F == 0);
    app = m_flag && (bnd || !en);
    @(posedge clk);
    m_t = nt;
    m_fs = bnd;
    if (app) begin m_active = m_pend; m_flag = 0; end
    if (acc) begin m_pend = load_data; m_flag = 1; end
    #1 check_outputs();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic load(input logic [15:0] v);
    int k = 0;
    while (m_flag && k < 100) begin step(); k++; end
    if (k == 100) chk("load_timeout", 1, 0);
    load_valid = 1; load_data = v;
    step();
    load_valid = 0;
  endtask
  task automatic wait_lit(input int d);
    int k = 0;
    while (!(((m_t % F) / P == d) && ((m_t % F) % P >= BL)) && k < 2 * F) begin step(); k++; end
    if (k == 2 * F) chk("wait_timeout", 1, 0);
  endtask
  task automatic model_reset();
    m_t = 0; m_active = 0; m_pend = 0; m_flag = 0; m_fs = 0;
  endtask
  initial begin
    tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 0);
    chk("rst_den", 32'(digit_en), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_ready", 32'(load_ready), 1);
    rst = 0;
    load(16'h1234);
    chk("pend_ready", 32'(load_ready), 0);
    run(2 * F);
    wait_lit(2);
    load(16'h5678);
    run(2 * F);
    lz_blank = 1;
    load(16'h0070);
    run(2 * F);
    load(16'h0000);
    run(2 * F);
    lz_blank = 0;
    load(16'h00AF);
    run(2 * F);
    wait_lit(1);
    en = 0;
    step();
    chk("en_off_den", 32'(digit_en), 0);
    chk("en_off_seg", 32'(seg), 0);
    run(3);
    en = 1;
    run(F + 4);
    load(16'h4321);
    wait_lit(0);
    en = 0;
    step();
    en = 1;
    run(F);
    load(16'h9876);
    wait_lit(1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_seg", 32'(seg), 0);
    chk("arst_den", 32'(digit_en), 0);
    chk("arst_ready", 32'(load_ready), 1);
    model_reset();
    @(negedge clk);
    rst = 0;
    run(2 * F);
    for (int i = 0; i < 800; i++) begin
      logic [15:0] v;
      for (int j = 0; j < 4; j++) v[4*j +: 4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 2) == 0) v = v & (16'hFFFF >> (4 * $urandom_range(1, 4)));
      load_data  = v;
      load_valid = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 59) == 0) lz_blank = ~lz_blank;
      en = ($urandom_range(0, 49) != 0);
      step();
    end
    load_valid = 0;
    en = 1;
    run(F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
